// File: rtl/regb_fifo_pkg.sv
// Shared types for the register-based FIFO serial reader.
// State encoding and serial line constants.
package regb_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/regb_ser_bit_tick.sv
// Bit-period divider: tick pulses once every CLK_DIV cycles.
// pre_tick flags that tick will be high in the next cycle.
module regb_ser_bit_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign pre_tick = (cnt_d == LAST);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regb_fifo_ser_reader.sv
// Pops words from the shift FIFO and sends each as a UART-style
// frame: start, data LSB first, optional even parity, stop.
module regb_fifo_ser_reader
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CLK_DIV   = 4,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             fifo_empty_n,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_shift_out,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             par_q, par_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pop, tick, pre_tick;

  // No pop strobe while reset is held, so no word is lost in reset.
  assign pop = res_n & enable & fifo_empty_n & (state_q == IDLE);

  regb_ser_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .res_n    (res_n),
    .clear    (pop),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          sh_d    = fifo_data;
          par_d   = ^fifo_data;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          ser_d   = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              ser_d   = par_q;
            end else begin
              state_d = STOP;
              ser_d   = LINE_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            sh_d  = sh_q >> 1;
            ser_d = sh_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          ser_d   = LINE_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Registered pulse lands on the final stop-bit cycle.
    done_d = (state_d == STOP) & pre_tick;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      ser_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_shift_out = pop;
  assign ser_out        = ser_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule
